// File: rtl/ldpc_frame_gen.sv
// -----------------------------------------------------------------------------
// ldpc_frame_gen
//
// Frame stimulus source for the DVB-S2 LDPC encoder. After enable rises it
// waits STARTUP_DLY cycles, then loops: wait for encoder rdy, issue a one-cycle
// SOF carrying MODCOD, stream max(cfg_len,1) data words (counter or PRBS-31),
// optionally idle for cfg_gap cycles, and repeat until cfg_nframes frames have
// been sent (0 = forever) or enable drops at a frame boundary.
//
// Ports:
//   clk, srst      clock, synchronous active-high reset
//   enable         run request (level); dropping it stops after current frame
//   cfg_mode       0 = counter data, 1 = PRBS-31 data
//   cfg_modcod     MODCOD presented on out_modcod with the SOF strobe
//   cfg_len        data words per frame (0 behaves as 1)
//   cfg_gap        idle cycles inserted between frames
//   cfg_nframes    frames per run, 0 = unlimited
//   dout_hold      throttle, suppresses the data beat in the current cycle
//   rdy            encoder ready, only looked at while waiting to start a frame
//   out_sof        one-cycle start-of-frame strobe
//   out_modcod     MODCOD latched at SOF, held until the next SOF
//   dout           data word (0 outside the data phase)
//   dout_valid     data beat qualifier
//   busy           high in every state except IDLE and DONE
//   done           sticky, requested frame count reached
//   frame_cnt      frames completed since the run started
// -----------------------------------------------------------------------------
module ldpc_frame_gen #(
  parameter int DW          = 16,
  parameter int MODCOD_W    = 5,
  parameter int LEN_W       = 16,
  parameter int NFR_W       = 16,
  parameter int STARTUP_DLY = 32
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                enable,
  input  logic                cfg_mode,
  input  logic [MODCOD_W-1:0] cfg_modcod,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic [LEN_W-1:0]    cfg_gap,
  input  logic [NFR_W-1:0]    cfg_nframes,
  input  logic                dout_hold,
  input  logic                rdy,
  output logic                out_sof,
  output logic [MODCOD_W-1:0] out_modcod,
  output logic [DW-1:0]       dout,
  output logic                dout_valid,
  output logic                busy,
  output logic                done,
  output logic [NFR_W-1:0]    frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STARTUP,
    S_WAIT_RDY,
    S_SOF,
    S_DATA,
    S_GAP,
    S_DONE
  } state_e;

  localparam int              SU_W      = (STARTUP_DLY > 1) ? $clog2(STARTUP_DLY) : 1;
  localparam int              SU_LAST_I = (STARTUP_DLY > 0) ? STARTUP_DLY - 1 : 0;
  localparam logic [SU_W-1:0] SU_LAST   = SU_LAST_I[SU_W-1:0];
  localparam logic [30:0]     LFSR_SEED = '1;

  state_e                state_q, state_d;
  logic [SU_W-1:0]       su_cnt_q, su_cnt_d;
  logic [LEN_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [LEN_W-1:0]      idx_q, idx_d;
  logic [30:0]           lfsr_q, lfsr_d;
  logic                  mode_q, mode_d;
  logic [LEN_W-1:0]      len_last_q, len_last_d;
  logic [LEN_W-1:0]      gap_q, gap_d;
  logic                  out_sof_q, out_sof_d;
  logic [MODCOD_W-1:0]   out_modcod_q, out_modcod_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [NFR_W-1:0]      frame_cnt_q, frame_cnt_d;

  logic [30:0]           lfsr_next;
  logic [NFR_W-1:0]      frame_cnt_inc;
  logic                  beat;
  logic [DW-1:0]         word;

  // x^31 + x^28 + 1, shifting towards the MSB.
  assign lfsr_next     = {lfsr_q[29:0], lfsr_q[30] ^ lfsr_q[27]};
  assign frame_cnt_inc = frame_cnt_q + NFR_W'(1);
  assign beat          = (state_q == S_DATA) && !dout_hold;
  assign word          = mode_q ? lfsr_q[DW-1:0] : DW'(idx_q);

  always_comb begin
    // NOTE: every _d starts as its _q so that no branch leaves a signal
    // unassigned; a missing default in always_comb infers a latch.
    state_d      = state_q;
    su_cnt_d     = su_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    idx_d        = idx_q;
    lfsr_d       = lfsr_q;
    mode_d       = mode_q;
    len_last_d   = len_last_q;
    gap_d        = gap_q;
    out_modcod_d = out_modcod_q;
    done_d       = done_q;
    frame_cnt_d  = frame_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          frame_cnt_d = '0;
          done_d      = 1'b0;
          su_cnt_d    = '0;
          state_d     = (STARTUP_DLY == 0) ? S_WAIT_RDY : S_STARTUP;
        end
      end

      S_STARTUP: begin
        if (su_cnt_q == SU_LAST) state_d = S_WAIT_RDY;
        else                     su_cnt_d = su_cnt_q + SU_W'(1);
      end

      S_WAIT_RDY: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (rdy) begin
          // Frame configuration is frozen here so mid-frame edits are ignored.
          state_d      = S_SOF;
          out_modcod_d = cfg_modcod;
          mode_d       = cfg_mode;
          len_last_d   = (cfg_len == '0) ? '0 : cfg_len - LEN_W'(1);
          gap_d        = cfg_gap;
          idx_d        = '0;
          lfsr_d       = LFSR_SEED;
        end
      end

      S_SOF: state_d = S_DATA;

      S_DATA: begin
        if (beat) begin
          idx_d  = idx_q + LEN_W'(1);
          lfsr_d = lfsr_next;
          if (idx_q == len_last_q) begin
            frame_cnt_d = frame_cnt_inc;
            if ((cfg_nframes != '0) && (frame_cnt_inc == cfg_nframes)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else if (!enable) begin
              state_d = S_IDLE;
            end else if (gap_q == '0) begin
              state_d = S_WAIT_RDY;
            end else begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
            end
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == gap_q - LEN_W'(1)) state_d = enable ? S_WAIT_RDY : S_IDLE;
        else                                gap_cnt_d = gap_cnt_q + LEN_W'(1);
      end

      S_DONE: begin
        if (!enable) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Registered status outputs track the state being entered.
    out_sof_d = (state_d == S_SOF);
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (srst) begin
      state_q      <= S_IDLE;
      su_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      idx_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      mode_q       <= 1'b0;
      len_last_q   <= '0;
      gap_q        <= '0;
      out_sof_q    <= 1'b0;
      out_modcod_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      su_cnt_q     <= su_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      idx_q        <= idx_d;
      lfsr_q       <= lfsr_d;
      mode_q       <= mode_d;
      len_last_q   <= len_last_d;
      gap_q        <= gap_d;
      out_sof_q    <= out_sof_d;
      out_modcod_q <= out_modcod_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // dout_valid follows dout_hold in the same cycle so a hold costs exactly
  // one beat; dout itself is a decode of registered state only.
  assign out_sof    = out_sof_q;
  assign out_modcod = out_modcod_q;
  assign dout       = (state_q == S_DATA) ? word : '0;
  assign dout_valid = beat;
  assign busy       = busy_q;
  assign done       = done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ldpc_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_ldpc_frame_gen
//
// Scenario tasks drive ldpc_frame_gen and compare observed beats, SOF timing
// and status against a reference model that computes each frame's words from
// the counter / PRBS-31 rules directly.
// -----------------------------------------------------------------------------
module tb_ldpc_frame_gen;
  localparam int DW = 16;
  localparam int MODCOD_W = 5;
  localparam int LEN_W = 16;
  localparam int NFR_W = 16;
  localparam int STARTUP_DLY = 32;

  logic                clk = 1'b0;
  logic                srst, enable, cfg_mode, dout_hold, rdy;
  logic [MODCOD_W-1:0] cfg_modcod;
  logic [LEN_W-1:0]    cfg_len, cfg_gap;
  logic [NFR_W-1:0]    cfg_nframes;
  logic                out_sof, dout_valid, busy, done;
  logic [MODCOD_W-1:0] out_modcod;
  logic [DW-1:0]       dout;
  logic [NFR_W-1:0]    frame_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ldpc_frame_gen #(
    .DW(DW), .MODCOD_W(MODCOD_W), .LEN_W(LEN_W), .NFR_W(NFR_W), .STARTUP_DLY(STARTUP_DLY)
  ) dut (
    .clk(clk), .srst(srst), .enable(enable), .cfg_mode(cfg_mode), .cfg_modcod(cfg_modcod),
    .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_nframes(cfg_nframes), .dout_hold(dout_hold),
    .rdy(rdy), .out_sof(out_sof), .out_modcod(out_modcod), .dout(dout),
    .dout_valid(dout_valid), .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  // Passive monitor, sampled mid-cycle.
  logic [DW-1:0]       beats[$];
  int                  beat_cyc[$];
  int                  sof_cyc[$];
  logic [MODCOD_W-1:0] sof_mc[$];
  int                  viol_both = 0;
  int                  viol_dout = 0;

  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      beats.push_back(dout);
      beat_cyc.push_back(cyc);
    end
    if (out_sof === 1'b1) begin
      sof_cyc.push_back(cyc);
      sof_mc.push_back(out_modcod);
    end
    if (out_sof === 1'b1 && dout_valid === 1'b1) viol_both <= viol_both + 1;
    if ((busy === 1'b0 || out_sof === 1'b1) && dout !== '0) viol_dout <= viol_dout + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Reference model: word i of any frame in the given mode.
  function automatic logic [DW-1:0] model_word(input bit mode, input int i);
    int unsigned l;
    if (!mode) return DW'(i);
    l = 32'h7fff_ffff;
    for (int k = 0; k < i; k++)
      l = ((l << 1) | (((l >> 30) ^ (l >> 27)) & 1)) & 32'h7fff_ffff;
    return l[DW-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    beats.delete(); beat_cyc.delete(); sof_cyc.delete(); sof_mc.delete();
  endtask

  task automatic set_cfg(input bit mode, input logic [MODCOD_W-1:0] mc,
                         input int len, input int gap, input int nfr);
    cfg_mode = mode; cfg_modcod = mc;
    cfg_len = LEN_W'(len); cfg_gap = LEN_W'(gap); cfg_nframes = NFR_W'(nfr);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      tick();
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_not_busy(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      tick();
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    srst = 1'b1; enable = 1'b1; rdy = 1'b1; dout_hold = 1'b0;
    set_cfg(1'b0, 5'h1f, 8, 0, 1);
    tick(); tick();
    @(negedge clk);
    total++; if (out_sof !== 1'b0) begin bad++; $display("FAIL reset_sof: got %b want 0", out_sof); end
    total++; if (out_modcod !== '0) begin bad++; $display("FAIL reset_modcod: got %h want 0", out_modcod); end
    total++; if (dout !== '0) begin bad++; $display("FAIL reset_dout: got %h want 0", dout); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (frame_cnt !== '0) begin bad++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    tick();
    srst = 1'b0; enable = 1'b0;
    tick();
  endtask

  task automatic test_counter_frame();
    logic [MODCOD_W-1:0] mc;
    int t0, lat;
    bit ok;
    mc = MODCOD_W'($urandom);
    set_cfg(1'b0, mc, 8, 0, 1); rdy = 1'b1; dout_hold = 1'b0;
    clear_mon();
    t0 = cyc; enable = 1'b1;
    wait_done(300, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL cnt_done_timeout: done not seen within 300 cycles"); end
    total++; if (sof_cyc.size() !== 1) begin bad++; $display("FAIL cnt_sof_count: got %0d want 1", sof_cyc.size()); end
    if (sof_cyc.size() >= 1) begin
      lat = sof_cyc[0] - t0;
      total++; if (!(lat >= 33 && lat <= 34)) begin bad++; $display("FAIL cnt_sof_latency: got %0d want 33..34", lat); end
      total++; if (sof_mc[0] !== mc) begin bad++; $display("FAIL cnt_sof_modcod: got %h want %h", sof_mc[0], mc); end
    end
    total++; if (beats.size() !== 8) begin bad++; $display("FAIL cnt_beat_count: got %0d want 8", beats.size()); end
    if (beats.size() == 8 && sof_cyc.size() >= 1) begin
      for (int i = 0; i < 8; i++) begin
        total++; if (beats[i] !== model_word(1'b0, i)) begin bad++; $display("FAIL cnt_word%0d: got %h want %h", i, beats[i], model_word(1'b0, i)); end
      end
      total++; if (beat_cyc[0] - sof_cyc[0] !== 1) begin bad++; $display("FAIL cnt_first_beat: got offset %0d want 1", beat_cyc[0] - sof_cyc[0]); end
      total++; if (beat_cyc[7] - beat_cyc[0] !== 7) begin bad++; $display("FAIL cnt_contiguous: got span %0d want 7", beat_cyc[7] - beat_cyc[0]); end
    end
    total++; if (frame_cnt !== 1) begin bad++; $display("FAIL cnt_frame_cnt: got %0d want 1", frame_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cnt_busy_done: got %b want 0", busy); end
    total++; if (out_modcod !== mc) begin bad++; $display("FAIL cnt_modcod_held: got %h want %h", out_modcod, mc); end
    enable = 1'b0;
    tick(); tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL cnt_done_sticky: got %b want 1", done); end
  endtask

  task automatic test_prbs_frames();
    bit ok;
    set_cfg(1'b1, MODCOD_W'($urandom), 4, $urandom_range(0, 3), 2);
    rdy = 1'b1; dout_hold = 1'b0;
    clear_mon();
    enable = 1'b1;
    wait_done(400, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL prbs_done_timeout: done not seen within 400 cycles"); end
    total++; if (beats.size() !== 8) begin bad++; $display("FAIL prbs_beat_count: got %0d want 8", beats.size()); end
    if (beats.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        total++; if (beats[i] !== model_word(1'b1, i % 4)) begin bad++; $display("FAIL prbs_word%0d: got %h want %h", i, beats[i], model_word(1'b1, i % 4)); end
      end
    end
    total++; if (frame_cnt !== 2) begin bad++; $display("FAIL prbs_frame_cnt: got %0d want 2", frame_cnt); end
    enable = 1'b0;
    tick(); tick();
  endtask

  task automatic test_throttle();
    bit seen, ok;
    set_cfg(1'b0, MODCOD_W'($urandom), 4, 0, 1);
    rdy = 1'b1; dout_hold = 1'b0;
    clear_mon();
    enable = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (out_sof === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL thr_sof_timeout: SOF not seen within 100 cycles"); end
    for (int k = 0; k < 8; k++) begin
      tick();
      dout_hold = (k % 2 == 0);
      @(negedge clk);
      total++; if (dout_valid !== logic'(k % 2)) begin bad++; $display("FAIL thr_valid%0d: got %b want %0d", k, dout_valid, k % 2); end
      total++; if (dout !== DW'(k / 2)) begin bad++; $display("FAIL thr_dout%0d: got %h want %h", k, dout, k / 2); end
    end
    tick();
    dout_hold = 1'b0;
    wait_done(10, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL thr_done_timeout: done not seen after 4 beats"); end
    total++; if (beats.size() !== 4) begin bad++; $display("FAIL thr_beat_count: got %0d want 4", beats.size()); end
    enable = 1'b0;
    tick(); tick();
  endtask

  task automatic test_gap_rdy();
    int len, rise_cyc;
    bit found, ok;
    len = $urandom_range(2, 6);
    set_cfg(1'b0, MODCOD_W'($urandom), len, 5, 3);
    rdy = 1'b1; dout_hold = 1'b0;
    clear_mon();
    enable = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      tick();
      if (frame_cnt === 1) found = 1'b1;
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL gap_frame1_timeout: first frame not completed"); end
    rdy = 1'b0;
    repeat (10) tick();
    rdy = 1'b1;
    rise_cyc = cyc;
    wait_done(300, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL gap_done_timeout: done not seen within 300 cycles"); end
    total++; if (sof_cyc.size() !== 3) begin bad++; $display("FAIL gap_sof_count: got %0d want 3", sof_cyc.size()); end
    total++; if (beats.size() !== 3 * len) begin bad++; $display("FAIL gap_beat_count: got %0d want %0d", beats.size(), 3 * len); end
    if (sof_cyc.size() == 3 && beats.size() == 3 * len) begin
      total++; if (sof_cyc[1] !== rise_cyc + 1) begin bad++; $display("FAIL gap_sof_after_rdy: got cycle %0d want %0d", sof_cyc[1], rise_cyc + 1); end
      total++; if (sof_cyc[1] - beat_cyc[len - 1] < 6) begin bad++; $display("FAIL gap_min_idle: got %0d want >=6", sof_cyc[1] - beat_cyc[len - 1]); end
      total++; if (sof_cyc[2] - beat_cyc[2 * len - 1] !== 7) begin bad++; $display("FAIL gap_exact: got %0d want 7", sof_cyc[2] - beat_cyc[2 * len - 1]); end
      for (int i = 0; i < 3 * len; i++) begin
        total++; if (beats[i] !== model_word(1'b0, i % len)) begin bad++; $display("FAIL gap_word%0d: got %h want %h", i, beats[i], model_word(1'b0, i % len)); end
      end
    end
    total++; if (frame_cnt !== 3) begin bad++; $display("FAIL gap_frame_cnt: got %0d want 3", frame_cnt); end
    enable = 1'b0;
    tick(); tick();
  endtask

  task automatic test_graceful_stop();
    int len, nsof;
    bit found, ok;
    len = $urandom_range(4, 8);
    set_cfg(1'b0, MODCOD_W'($urandom), len, $urandom_range(0, 3), 0);
    rdy = 1'b1; dout_hold = 1'b0;
    clear_mon();
    enable = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      tick();
      if (beats.size() >= len + 2) found = 1'b1;
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL stop_frame2_timeout: frame 2 not reached"); end
    enable = 1'b0;
    wait_not_busy(200, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL stop_idle_timeout: busy still high after 200 cycles"); end
    total++; if (beats.size() !== 2 * len) begin bad++; $display("FAIL stop_beat_count: got %0d want %0d", beats.size(), 2 * len); end
    if (beats.size() == 2 * len) begin
      for (int i = 0; i < 2 * len; i++) begin
        total++; if (beats[i] !== model_word(1'b0, i % len)) begin bad++; $display("FAIL stop_word%0d: got %h want %h", i, beats[i], model_word(1'b0, i % len)); end
      end
    end
    total++; if (frame_cnt !== 2) begin bad++; $display("FAIL stop_frame_cnt: got %0d want 2", frame_cnt); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL stop_done: got %b want 0", done); end
    nsof = sof_cyc.size();
    repeat (5) tick();
    total++; if (sof_cyc.size() !== 2 || nsof !== 2) begin bad++; $display("FAIL stop_no_more_sof: got %0d want 2", sof_cyc.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int t0, lat;
    bit found, ok;
    set_cfg(1'b0, MODCOD_W'($urandom) | 5'h1, 8, 0, 0);
    rdy = 1'b1; dout_hold = 1'b0;
    clear_mon();
    enable = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (dout_valid === 1'b1 && dout === DW'(3)) found = 1'b1;
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL rst_beat3_timeout: beat 3 not seen"); end
    srst = 1'b1;
    @(negedge clk);
    total++; if (out_sof !== 1'b0) begin bad++; $display("FAIL rst_mid_sof: got %b want 0", out_sof); end
    total++; if (out_modcod !== '0) begin bad++; $display("FAIL rst_mid_modcod: got %h want 0", out_modcod); end
    total++; if (dout !== '0) begin bad++; $display("FAIL rst_mid_dout: got %h want 0", dout); end
    total++; if (dout_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", dout_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    total++; if (frame_cnt !== '0) begin bad++; $display("FAIL rst_mid_frame_cnt: got %0d want 0", frame_cnt); end
    tick();
    srst = 1'b0;
    clear_mon();
    t0 = cyc;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick();
      if (beats.size() >= 1) found = 1'b1;
    end
    total++; if (found !== 1'b1 || sof_cyc.size() < 1) begin bad++; $display("FAIL rst_restart_timeout: no beat after restart"); end
    if (found && sof_cyc.size() >= 1) begin
      lat = sof_cyc[0] - t0;
      total++; if (!(lat >= 33 && lat <= 34)) begin bad++; $display("FAIL rst_restart_latency: got %0d want 33..34", lat); end
      total++; if (beats[0] !== '0) begin bad++; $display("FAIL rst_restart_word0: got %h want 0", beats[0]); end
    end
    enable = 1'b0;
    wait_not_busy(100, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rst_stop_timeout: busy still high"); end
  endtask

  task automatic test_random_frames();
    logic [DW-1:0] exp_q[$];
    logic [MODCOD_W-1:0] mc;
    bit mode, ok;
    int len, nfr, eff;
    for (int it = 0; it < 3; it++) begin
      mode = 1'($urandom);
      len = (it == 0) ? 0 : $urandom_range(1, 6);
      nfr = $urandom_range(1, 3);
      mc = MODCOD_W'($urandom);
      set_cfg(mode, mc, len, $urandom_range(0, 3), nfr);
      clear_mon();
      enable = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 2000 && !ok; k++) begin
        tick();
        dout_hold = ($urandom_range(0, 3) == 0);
        rdy = 1'($urandom);
        if (done === 1'b1) ok = 1'b1;
      end
      dout_hold = 1'b0; rdy = 1'b1;
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL rnd%0d_done_timeout: done not seen", it); end
      eff = (len == 0) ? 1 : len;
      exp_q.delete();
      for (int f = 0; f < nfr; f++)
        for (int i = 0; i < eff; i++) exp_q.push_back(model_word(mode, i));
      total++; if (beats.size() !== exp_q.size()) begin bad++; $display("FAIL rnd%0d_beat_count: got %0d want %0d", it, beats.size(), exp_q.size()); end
      if (beats.size() == exp_q.size()) begin
        for (int i = 0; i < exp_q.size(); i++) begin
          total++; if (beats[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_word%0d: got %h want %h", it, i, beats[i], exp_q[i]); end
        end
      end
      total++; if (sof_cyc.size() !== nfr) begin bad++; $display("FAIL rnd%0d_sof_count: got %0d want %0d", it, sof_cyc.size(), nfr); end
      foreach (sof_mc[i]) begin
        total++; if (sof_mc[i] !== mc) begin bad++; $display("FAIL rnd%0d_modcod%0d: got %h want %h", it, i, sof_mc[i], mc); end
      end
      total++; if (frame_cnt !== NFR_W'(nfr)) begin bad++; $display("FAIL rnd%0d_frame_cnt: got %0d want %0d", it, frame_cnt, nfr); end
      enable = 1'b0;
      tick(); tick();
    end
  endtask

  task automatic test_invariants();
    total++; if (viol_both !== 0) begin bad++; $display("FAIL inv_sof_and_valid: got %0d cycles want 0", viol_both); end
    total++; if (viol_dout !== 0) begin bad++; $display("FAIL inv_dout_zero_idle: got %0d cycles want 0", viol_dout); end
  endtask

  initial begin
    srst = 1'b1; enable = 1'b0; rdy = 1'b0; dout_hold = 1'b0;
    set_cfg(1'b0, '0, 1, 0, 1);
    test_reset();
    test_counter_frame();
    test_prbs_frames();
    test_throttle();
    test_gap_rdy();
    test_graceful_stop();
    test_reset_mid_frame();
    test_random_frames();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldpc_frame_gen.md
Name: ldpc_frame_gen

Overview:
Parametrised frame stimulus source for the DVB-S2 LDPC encoder (ldpc_enc_64800 and successors).
- Waits for encoder rdy, issues a one-cycle SOF with MODCOD, then streams a programmable number of data words.
- Data is either an incrementing counter or PRBS-31, with optional inter-frame gaps, throttling and a frame count.
- Used in simulation benches and as an on-chip BIST source ahead of the encoder.

Parameters:
DW, 16, data word width (1..31)
MODCOD_W, 5, width of MODCOD field
LEN_W, 16, width of frame-length and gap counters
NFR_W, 16, width of frame counter
STARTUP_DLY, 32, cycles to wait after leaving IDLE before first rdy check (0 = none)

Ports:
clk  in  1  system clock
srst  in  1  synchronous active-high reset
enable  in  1  level; 1 = run, 0 = stop after current frame
cfg_mode  in  1  0 = counter data, 1 = PRBS-31 data
cfg_modcod  in  MODCOD_W  MODCOD presented with SOF
cfg_len  in  LEN_W  data words per frame (0 treated as 1)
cfg_gap  in  LEN_W  idle cycles between frames
cfg_nframes  in  NFR_W  frames to send; 0 = unlimited
dout_hold  in  1  throttle; 1 suppresses data beat this cycle
rdy  in  1  encoder ready for new frame
out_sof  out  1  one-cycle start-of-frame strobe
out_modcod  out  MODCOD_W  MODCOD, valid with out_sof, held until next SOF
dout  out  DW  data word
dout_valid  out  1  data beat qualifier
busy  out  1  1 in any state except IDLE/DONE
done  out  1  sticky; requested frame count reached
frame_cnt  out  NFR_W  frames completed since leaving IDLE

Behaviour:
- Reset: srst=1 forces state IDLE at next edge, from any state including mid-frame. All outputs 0; LFSR = all ones; counters 0.
- States: IDLE, STARTUP, WAIT_RDY, SOF, DATA, GAP, DONE.
- IDLE:
  - enable=1 -> STARTUP; frame_cnt cleared; done cleared.
  - If STARTUP_DLY=0, go directly to WAIT_RDY.
- STARTUP: counts STARTUP_DLY cycles, then WAIT_RDY. Entered only once per run; not revisited between frames.
- WAIT_RDY:
  - rdy sampled each edge; rdy=1 -> SOF.
  - enable=0 here -> IDLE.
- SOF (exactly 1 cycle):
  - out_sof=1; out_modcod = cfg_modcod.
  - Latch cfg_mode, cfg_len and cfg_gap; config changes mid-frame have no effect.
  - Word counter <= 0; LFSR reseeded to all ones. Every frame in a mode is therefore identical.
- DATA:
  - Each cycle with dout_hold=0: dout_valid=1, then word index and LFSR advance.
  - dout_hold=1: dout_valid=0; dout, index and LFSR frozen.
  - Counter mode: dout = word index (0,1,2,...), truncated to DW.
  - PRBS mode: 31-bit LFSR, poly x^31+x^28+1. Next = {lfsr[29:0], lfsr[30]^lfsr[27]}. dout = lfsr[DW-1:0] before advance.
  - First beat follows the SOF cycle directly (no gap) when hold=0.
  - After beat number max(cfg_len,1), frame_cnt increments (wraps at 2^NFR_W), then:
    - cfg_nframes!=0 and new frame_cnt == cfg_nframes -> DONE;
    - else enable=0 -> IDLE;
    - else cfg_gap=0 -> WAIT_RDY;
    - else -> GAP.
- GAP: dout_valid=0 for latched cfg_gap cycles, then WAIT_RDY (or IDLE if enable=0 at exit).
- DONE:
  - done=1, busy=0, outputs idle.
  - Remains until enable=0 (-> IDLE, done held until next start) or srst.
- dout_valid and out_sof never assert together. dout is 0 outside DATA.
- rdy is ignored outside WAIT_RDY; deassertion during DATA does not stall.

Test Plan:
- Counter frame: STARTUP_DLY=32, cfg_len=8, cfg_nframes=1, rdy=1, enable rises at t0 -> out_sof exactly once, 33-34 cycles after enable; dout 0..7 on 8 consecutive valid cycles; done=1; frame_cnt=1.
- PRBS frame: cfg_mode=1, DW=16, cfg_len=4 -> dout = 0xFFFF, 0xFFFE, 0xFFFC, 0xFFF8; second frame repeats the identical sequence.
- Throttle: cfg_len=4, dout_hold toggled 1/0 each cycle in DATA -> exactly 4 valid beats 0,1,2,3 spread over 8 cycles; values frozen during holds.
- Gap and rdy: cfg_nframes=3, cfg_gap=5, rdy held low 10 cycles after frame 1 -> at least 5 idle cycles and no SOF until rdy=1; frame_cnt ends at 3; done=1.
- Graceful stop: cfg_nframes=0, enable dropped mid-DATA of frame 2 -> frame 2 completes all cfg_len beats, then IDLE; busy=0; done=0.
- Reset mid-frame: srst asserted during DATA beat 3 -> next cycle all outputs 0, state IDLE; re-enable restarts with STARTUP delay and word 0.
